// File: rtl/config_shift_sequencer.sv
// Fabric configuration chain sequencer: streams 32-bit words onto four
// parallel shift chains, then pulses the per-chain set lines to commit.
module config_shift_sequencer #(
  parameter int CHAIN_LEN  = 64,
  parameter int SET_CYCLES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [3:0]  set_mask_i,
  input  logic        word_valid_i,
  input  logic [31:0] word_data_i,
  output logic        word_ready_o,
  output logic        cen_o,
  output logic [3:0]  shift_o,
  output logic [3:0]  set_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int NWORDS = CHAIN_LEN / 8;
  localparam int WW = $clog2(NWORDS + 1);
  localparam int SW = $clog2(SET_CYCLES + 1);
  localparam logic [WW-1:0] WLOAD = WW'(NWORDS);
  localparam logic [SW-1:0] SLAST = SW'(SET_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    SET,
    DONE
  } state_t;

  state_t        state;
  logic [31:0]   sreg;
  logic [2:0]    beat;
  logic [WW-1:0] wcnt;
  logic [SW-1:0] scnt;
  logic [3:0]    mask;
  logic          last_beat;
  logic          take;

  assign last_beat = (beat == 3'd7);

  // Ready is the only output that sees an input, so abort can veto it.
  assign word_ready_o = !abort_i &&
    ((state == LOAD) ||
     (state == SHIFT && last_beat && wcnt != '0));
  assign take = word_ready_o && word_valid_i;

  assign cen_o   = (state == SHIFT);
  assign shift_o = cen_o ? sreg[3:0] : 4'h0;
  assign set_o   = (state == SET) ? mask : 4'h0;
  assign busy_o  = (state != IDLE);
  assign done_o  = (state == DONE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= IDLE;
      sreg  <= '0;
      beat  <= '0;
      wcnt  <= '0;
      scnt  <= '0;
      mask  <= '0;
    end else if (abort_i) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state <= LOAD;
            mask  <= set_mask_i;
            wcnt  <= WLOAD;
          end
        end
        LOAD: begin
          if (take) begin
            sreg  <= word_data_i;
            beat  <= '0;
            wcnt  <= wcnt - WW'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= sreg >> 4;
          beat <= beat + 3'd1;
          if (last_beat) begin
            if (wcnt == '0) begin
              state <= SET;
              scnt  <= '0;
            end else if (take) begin
              sreg <= word_data_i;
              beat <= '0;
              wcnt <= wcnt - WW'(1);
            end else begin
              state <= LOAD;
            end
          end
        end
        SET: begin
          if (scnt == SLAST) begin
            state <= DONE;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/config_shift_sequencer.md
# config_shift_sequencer

Sequencer that drives the fabric configuration chains. It takes 32-bit configuration words over a valid/ready stream and serialises them onto four parallel shift chains, gated by a chain-enable strobe. Once every chain holds CHAIN_LEN bits, it pulses the per-chain set lines to commit the loaded configuration. It sits between the Wishbone-facing bitstream buffer and the fabric `cen` / `shift` / `set` inputs, and is the only agent that toggles them.

## Interface
- CHAIN_LEN, 64: bits per chain. Must be a multiple of 8 and ≥ 8. Words per load is NWORDS = CHAIN_LEN/8.
- SET_CYCLES, 2: cycles the set lines are held high. Must be ≥ 1.

Ports:
- wb_clk_i  in  1  clock; all state updates on the rising edge
- wb_rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  begin a load; sampled only in IDLE
- abort_i  in  1  cancel the load from any non-IDLE state
- set_mask_i  in  4  chains to commit; latched on an accepted start
- word_valid_i  in  1  word_data_i is valid
- word_data_i  in  32  configuration word
- word_ready_o  out  1  sequencer accepts the word this cycle
- cen_o  out  1  chain shift enable
- shift_o  out  4  serial data, bit i goes to chain i
- set_o  out  4  per-chain commit strobe
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse when a load completes

## Operation
States:
- IDLE:
  - start_i=1 → LOAD.
  - Latch set_mask_i.
  - Word counter wcnt ← NWORDS.
- LOAD:
  - word_ready_o=1.
  - On valid&ready: sreg ← word_data_i, beat ← 0, wcnt ← wcnt−1, go to SHIFT.
  - Otherwise stay in LOAD with no timeout.
- SHIFT:
  - cen_o=1 and shift_o=sreg[3:0].
  - Each cycle: sreg ← sreg>>4, beat ← beat+1.
  - On beat k, chain i receives word bit 4k+i. Bit 0 is shifted first.
  - At beat=7:
    - wcnt>0: word_ready_o=1.
      - If valid: load the next word, beat ← 0, stay in SHIFT (no bubble).
      - Else go to LOAD.
    - wcnt=0: go to SET, set counter ← 0.
- SET:
  - set_o = latched mask and cen_o=0.
  - Stay for SET_CYCLES cycles, then go to DONE.
- DONE:
  - done_o=1 for this one cycle, then go to IDLE.

Output and handshake rules:
- word_ready_o is high only in LOAD, or in SHIFT with beat=7 and wcnt>0. Words offered at any other time are not consumed.
- cen_o, shift_o and set_o are decoded from registered state only, with no combinational path from inputs.
- shift_o=0 whenever cen_o=0.
- set_o is never high in the same cycle as cen_o.

Priority and boundary cases:
- abort_i has priority over everything, including a same-cycle start_i or handshake.
  - Next state is IDLE. No set pulse, no done_o.
  - A word presented in the abort cycle is not accepted (word_ready_o=0 while abort_i=1).
- start_i outside IDLE is ignored.
- set_mask_i=0 still runs SET and DONE with set_o=0.
- Back-to-back loads: start_i may be asserted during DONE but is ignored. The earliest new start is sampled in the following IDLE cycle.

Reset (wb_rst_ni=0, including mid-operation):
- State IDLE, all counters and sreg cleared.
- Every output low, including word_ready_o.

## Timing
- start_i sampled at edge T0 → LOAD in cycle 1.
- A word accepted at edge Tn → its first shift beat in cycle n+1, 8 beats total.
- Zero-stall load, total busy cycles: 1 (LOAD) + 8·NWORDS + SET_CYCLES + 1 (DONE). With defaults: 1+64+2+1 = 68.
- Each stall cycle (word_valid_i low while ready) adds exactly one cycle with cen_o=0.
- Counter widths:
  - beat: 3 bits.
  - wcnt: ⌈log2(NWORDS+1)⌉ bits.
  - SET counter: ⌈log2(SET_CYCLES+1)⌉ bits.
  - No wrap is reachable.

## Test plan
- Reset mid-SHIFT (beat 3 of word 2) → all outputs 0 asynchronously; after release, busy_o=0 and start_i is accepted normally.
- CHAIN_LEN=16, SET_CYCLES=2, words 0x76543210 and 0xFEDCBA98 held valid, mask 4'b1011:
  - shift_o = 0,1,…,F over 16 consecutive cen_o cycles.
  - set_o=4'b1011 for 2 cycles, then done_o for 1 cycle.
  - busy_o high for 20 cycles.
- Same load with word_valid_i low for 3 cycles between words → exactly 3 cen_o=0 gap cycles in LOAD, 23 busy cycles, bit order unchanged.
- abort_i asserted at beat 5 of word 1 → IDLE next cycle; set_o and done_o never assert; the next start reloads from word 0.
- start_i pulsed during SHIFT and DONE → ignored, no second load. A start in the IDLE cycle after DONE is accepted.
- Word offered with valid=1 during SET/DONE/IDLE → word_ready_o=0, no handshake, sreg unchanged.
